longbidiv: RTL and testbench

LONGBIDIV -- requirements
Module: longbidiv

---
 rtl/longbidiv.sv | 141 ++++++++++++++
 tb/tb_longbidiv.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/longbidiv.sv
// longbidiv: sequential signed long division, one restoring radix-2 step per clock.
//
// Parameters
//   IAW    dividend / quotient width (signed, >= 2)
//   IBW    divisor / remainder width (signed, >= 2)
//
// Ports
//   i_clk    clock, all state changes on the rising edge
//   i_reset  asynchronous active-high reset
//   i_wr     start request, taken when o_busy is low
//   i_num    two's-complement dividend
//   i_den    two's-complement divisor
//   o_busy   division in flight; i_wr is ignored while high
//   o_valid  one-cycle strobe, o_quo/o_rem/o_err updated on the same edge
//   o_quo    signed quotient, truncated toward zero
//   o_rem    signed remainder, sign of the dividend
//   o_err    divide-by-zero or overflow (-2^(IAW-1) / -1), qualified by o_valid
//
// Handshake: a request is accepted on a rising edge where i_wr=1 and o_busy=0
// (edge t0). The result strobe o_valid is high after edge t0+IAW+1 for exactly
// one cycle, and a new request may be accepted on that same strobe cycle.
// Results hold their value until the next strobe.
module longbidiv #(
  parameter int IAW = 16,
  parameter int IBW = 12
) (
  input  logic           i_clk,
  input  logic           i_reset,
  input  logic           i_wr,
  input  logic [IAW-1:0] i_num,
  input  logic [IBW-1:0] i_den,
  output logic           o_busy,
  output logic           o_valid,
  output logic [IAW-1:0] o_quo,
  output logic [IBW-1:0] o_rem,
  output logic           o_err
);

  localparam int CW = (IAW > 2) ? $clog2(IAW) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DIV  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t state, state_next;

  logic [CW-1:0]  cnt;
  // acc starts as the dividend magnitude; each step shifts one dividend bit
  // out of the top and one quotient bit in at the bottom, so after IAW steps
  // it holds the quotient magnitude.
  logic [IAW-1:0] acc;
  logic [IBW-1:0] den_mag;
  logic [IBW:0]   prem;
  logic           q_sign;
  logic           r_sign;
  logic           den_zero;

  logic [IAW-1:0] num_abs;
  logic [IBW-1:0] den_abs;
  logic [IBW:0]   shifted;
  logic [IBW:0]   diff;
  logic           q_bit;

  // Magnitudes: the most-negative value negates to itself, which read as
  // unsigned is exactly 2^(W-1).
  always_comb begin
    num_abs = i_num[IAW-1] ? -i_num : i_num;
    den_abs = i_den[IBW-1] ? -i_den : i_den;
  end

  // One restoring step. The compare spans the whole partial remainder so the
  // top bit (always clear between steps) still takes part in the decision.
  always_comb begin
    shifted = {prem[IBW-1:0], acc[IAW-1]};
    q_bit   = ({prem, acc[IAW-1]} >= {2'b00, den_mag});
    diff    = shifted - {1'b0, den_mag};
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (i_wr) state_next = S_DIV;
      S_DIV:  if (cnt == '0) state_next = S_FIX;
      S_FIX:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      acc      <= '0;
      den_mag  <= '0;
      prem     <= '0;
      q_sign   <= 1'b0;
      r_sign   <= 1'b0;
      den_zero <= 1'b0;
      o_busy   <= 1'b0;
      o_valid  <= 1'b0;
      o_quo    <= '0;
      o_rem    <= '0;
      o_err    <= 1'b0;
    end else begin
      state   <= state_next;
      o_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_wr) begin
            acc      <= num_abs;
            den_mag  <= den_abs;
            prem     <= '0;
            q_sign   <= i_num[IAW-1] ^ i_den[IBW-1];
            r_sign   <= i_num[IAW-1];
            den_zero <= (i_den == '0);
            cnt      <= CW'(IAW - 1);
            o_busy   <= 1'b1;
          end
        end
        S_DIV: begin
          prem <= q_bit ? diff : shifted;
          acc  <= {acc[IAW-2:0], q_bit};
          if (cnt != '0) cnt <= cnt - CW'(1);
        end
        S_FIX: begin
          o_quo   <= den_zero ? '0 : (q_sign ? -acc : acc);
          o_rem   <= den_zero ? '0 : (r_sign ? -prem[IBW-1:0] : prem[IBW-1:0]);
          // A positive quotient with magnitude 2^(IAW-1) cannot be represented;
          // it only arises from -2^(IAW-1) / -1 and is output wrapped.
          o_err   <= den_zero | (~q_sign & acc[IAW-1]);
          o_valid <= 1'b1;
          o_busy  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_longbidiv.sv
// tb_longbidiv: self-checking bench for longbidiv (IAW=16, IBW=12).
// Directed table vectors, reset/abort and busy sequences, then a random
// regression on four extra lanes running in lockstep, checked against an
// integer-arithmetic reference model.
module tb_longbidiv;
  localparam int IAW = 16;
  localparam int IBW = 12;
  localparam int W   = IAW + IBW + 1;
  localparam int NL  = 4;
  localparam int NR  = 2500;
  localparam int LAT = IAW + 1;

  logic           i_clk;
  logic           i_reset;
  logic           i_wr;
  logic [IAW-1:0] i_num;
  logic [IBW-1:0] i_den;
  logic           o_busy;
  logic           o_valid;
  logic [IAW-1:0] o_quo;
  logic [IBW-1:0] o_rem;
  logic           o_err;

  longbidiv #(.IAW(IAW), .IBW(IBW)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_wr(i_wr), .i_num(i_num), .i_den(i_den),
    .o_busy(o_busy), .o_valid(o_valid), .o_quo(o_quo), .o_rem(o_rem), .o_err(o_err)
  );

  // regression lanes
  logic           l_wr;
  logic [IAW-1:0] l_num[NL];
  logic [IBW-1:0] l_den[NL];
  logic           l_busy[NL];
  logic           l_valid[NL];
  logic [IAW-1:0] l_quo[NL];
  logic [IBW-1:0] l_rem[NL];
  logic           l_err[NL];
  logic [W-1:0]   l_exp[NL];

  for (genvar g = 0; g < NL; g++) begin : g_lane
    longbidiv #(.IAW(IAW), .IBW(IBW)) u_lane (
      .i_clk(i_clk), .i_reset(i_reset), .i_wr(l_wr), .i_num(l_num[g]), .i_den(l_den[g]),
      .o_busy(l_busy[g]), .o_valid(l_valid[g]), .o_quo(l_quo[g]), .o_rem(l_rem[g]),
      .o_err(l_err[g])
    );
  end

  // clock / reset
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #1500000;
    $display("FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  int n_pass;
  int n_total;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h", name, act, exp);
  endtask

  // Reference model: plain signed integer arithmetic. SV '/' truncates toward
  // zero and '%' takes the sign of the dividend.
  function automatic logic [W-1:0] ref_div(input logic [IAW-1:0] n, input logic [IBW-1:0] d);
    longint sn, sd, q, r, qmax;
    logic e;
    sn   = longint'($signed(n));
    sd   = longint'($signed(d));
    qmax = (longint'(1) << (IAW - 1)) - 1;
    if (sd == 0) begin
      q = 0; r = 0; e = 1'b1;
    end else begin
      q = sn / sd;
      r = sn % sd;
      e = (q > qmax);
    end
    return {q[IAW-1:0], r[IBW-1:0], e};
  endfunction

  function automatic logic [IAW-1:0] rand_num();
    case ($urandom_range(0, 7))
      0: return {1'b1, {(IAW-1){1'b0}}};
      1: return '1;
      2: return '0;
      3: return IAW'($urandom_range(0, 20));
      default: return IAW'($urandom);
    endcase
  endfunction

  function automatic logic [IBW-1:0] rand_den();
    case ($urandom_range(0, 9))
      0: return '0;
      1: return {1'b1, {(IBW-1){1'b0}}};
      2: return '1;
      3: return IBW'(1);
      4: return IBW'($urandom_range(0, 16)) - IBW'(8);
      default: return IBW'($urandom);
    endcase
  endfunction

  // Driver: called at a negedge with the DUT idle or strobing. Accepts on the
  // next posedge, returns at the negedge where o_valid is seen (lat = edges
  // after accept, -1 on timeout).
  task automatic run_op(input logic [IAW-1:0] n, input logic [IBW-1:0] d,
                        output logic [W-1:0] res, output int lat);
    i_num = n; i_den = d; i_wr = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    i_wr = 1'b0;
    lat = -1;
    res = '0;
    for (int k = 0; k < 40; k++) begin
      if (k > 0) @(negedge i_clk);
      if (o_valid) begin
        lat = k;
        res = {o_quo, o_rem, o_err};
        break;
      end
    end
  endtask

  typedef struct {
    logic [IAW-1:0] num;
    logic [IBW-1:0] den;
    logic [IAW-1:0] quo;
    logic [IBW-1:0] rem;
    logic           err;
    string          name;
  } vec_t;

  vec_t         vecs[13];
  logic [W-1:0] exp_q[$];
  logic [W-1:0] res, held, e;
  int           lat, last_acc, nvalid, vseen, bseen;
  logic         seen_v;

  initial begin
    n_pass = 0;
    n_total = 0;
    i_wr = 1'b0; i_num = '0; i_den = '0; l_wr = 1'b0;
    for (int g = 0; g < NL; g++) begin l_num[g] = '0; l_den[g] = '0; end

    vecs[0]  = '{16'd100,     12'd7,     16'd14,     12'd2,     1'b0, "100/7"};
    vecs[1]  = '{-16'sd100,   12'd7,     -16'sd14,   -12'sd2,   1'b0, "-100/7"};
    vecs[2]  = '{16'd100,     -12'sd7,   -16'sd14,   12'd2,     1'b0, "100/-7"};
    vecs[3]  = '{-16'sd100,   -12'sd7,   16'd14,     -12'sd2,   1'b0, "-100/-7"};
    vecs[4]  = '{16'd1234,    12'd0,     16'd0,      12'd0,     1'b1, "1234/0"};
    vecs[5]  = '{16'h8000,    -12'sd1,   16'h8000,   12'd0,     1'b1, "-32768/-1"};
    vecs[6]  = '{16'h8000,    12'h800,   16'd16,     12'd0,     1'b0, "-32768/-2048"};
    vecs[7]  = '{16'd32767,   12'd1,     16'd32767,  12'd0,     1'b0, "32767/1"};
    vecs[8]  = '{16'h8000,    12'd1,     16'h8000,   12'd0,     1'b0, "-32768/1"};
    vecs[9]  = '{16'd7,       12'd100,   16'd0,      12'd7,     1'b0, "7/100"};
    vecs[10] = '{16'd1000,    12'h800,   16'd0,      12'd1000,  1'b0, "1000/-2048"};
    vecs[11] = '{16'h8000,    12'd2047,  -16'sd16,   -12'sd16,  1'b0, "-32768/2047"};
    vecs[12] = '{16'd32767,   12'h800,   -16'sd15,   12'd2047,  1'b0, "32767/-2048"};

    // reset state
    i_reset = 1'b1;
    repeat (2) @(negedge i_clk);
    chk("reset_outputs", {o_busy, o_valid, o_quo, o_rem, o_err}, '0);
    i_reset = 1'b0;

    // table vectors; the first is accepted on the first edge after reset
    // release, the rest back-to-back on the strobe cycle
    foreach (vecs[i]) begin
      run_op(vecs[i].num, vecs[i].den, res, lat);
      chk({"lat ", vecs[i].name}, 64'(lat), 64'(LAT));
      chk({"res ", vecs[i].name}, res, {vecs[i].quo, vecs[i].rem, vecs[i].err});
    end

    // abort: reset at t0+5, asynchronous effect checked between edges
    @(negedge i_clk);
    i_num = 16'd100; i_den = 12'd7; i_wr = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    i_wr = 1'b0;
    repeat (4) @(posedge i_clk);
    #1 i_reset = 1'b1;
    #1 chk("abort_async", {o_busy, o_valid, o_quo, o_rem, o_err}, '0);
    @(negedge i_clk);
    i_reset = 1'b0;
    vseen = 0; bseen = 0;
    repeat (20) begin
      @(negedge i_clk);
      if (o_valid) vseen++;
      if (o_busy) bseen++;
    end
    chk("abort_no_valid", 64'(vseen), 64'd0);
    chk("abort_no_busy", 64'(bseen), 64'd0);
    run_op(16'd1000, 12'd33, res, lat);
    chk("after_abort_lat", 64'(lat), 64'(LAT));
    chk("after_abort_res", res, {16'd30, 12'd10, 1'b0});

    // busy: i_wr held 40 cycles with changing operands
    exp_q.delete();
    last_acc = -100;
    nvalid = 0;
    seen_v = 1'b0;
    held = '0;
    for (int c = 0; c < 60; c++) begin
      @(negedge i_clk);
      chk($sformatf("busy_c%0d", c), 64'(o_busy), 64'((c - last_acc >= 1) && (c - last_acc <= LAT)));
      chk($sformatf("valid_c%0d", c), 64'(o_valid), 64'(c - last_acc == LAT + 1));
      if (o_valid) begin
        nvalid++;
        seen_v = 1'b1;
        held = {o_quo, o_rem, o_err};
        if (exp_q.size() == 0) chk("busy_unexpected_valid", 64'd1, 64'd0);
        else begin
          e = exp_q.pop_front();
          chk($sformatf("busy_res_c%0d", c), held, e);
        end
      end else if (seen_v) begin
        chk($sformatf("hold_c%0d", c), {o_quo, o_rem, o_err}, held);
      end
      if (c < 40) begin
        i_wr = 1'b1;
        i_num = rand_num();
        i_den = rand_den();
        if (c - last_acc >= LAT + 1) begin
          exp_q.push_back(ref_div(i_num, i_den));
          last_acc = c;
        end
      end else begin
        i_wr = 1'b0;
      end
    end
    chk("busy_results", 64'(nvalid), 64'd3);
    chk("busy_queue_empty", 64'(exp_q.size()), 64'd0);

    // random regression, lanes restarted back-to-back on each strobe
    @(negedge i_clk);
    for (int r = 0; r < NR; r++) begin
      for (int g = 0; g < NL; g++) begin
        l_num[g] = rand_num();
        l_den[g] = rand_den();
        l_exp[g] = ref_div(l_num[g], l_den[g]);
      end
      l_wr = 1'b1;
      @(posedge i_clk);
      @(negedge i_clk);
      l_wr = 1'b0;
      lat = -1;
      for (int k = 0; k < 40; k++) begin
        if (k > 0) @(negedge i_clk);
        if (l_valid[0]) begin lat = k; break; end
      end
      chk($sformatf("reg_lat_r%0d", r), 64'(lat), 64'(LAT));
      for (int g = 0; g < NL; g++) begin
        chk($sformatf("reg_r%0d_l%0d %0d/%0d", r, g, $signed(l_num[g]), $signed(l_den[g])),
            {l_valid[g], l_quo[g], l_rem[g], l_err[g]}, {1'b1, l_exp[g]});
      end
      if (lat < 0) break;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
